obstacle_spawner: RTL and testbench
===================================

# obstacle_spawner

Obstacle scheduler for Dino Run, directly downstream of the 16-bit LFSR random source. Consumes one random word per decision, using it to choose the inter-obstacle gap and the obstacle type. It then scrolls a single active obstacle leftward once per video frame and reports its position and type to the renderer and collision logic. It also issues the advance request back to the LFSR each time a random word is consumed.

## Interface
- SCREEN_W, 640: spawn x-coordinate is SCREEN_W-1; range 2..1023.
- MIN_GAP, 20: minimum frames between obstacles; range 1..192, so MIN_GAP+63 ≤ 255.
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- run_i  input  1  game running level; low forces IDLE.
- frame_i  input  1  one-cycle frame tick; never asserted in two consecutive cycles.
- speed_i  input  4  scroll pixels per frame, sampled on each frame_i.
- rand_i  input  16  current LFSR word.
- next_o  output  1  LFSR advance request; one-cycle pulse.
- obs_valid_o  output  1  an obstacle is on screen.
- obs_x_o  output  10  obstacle left-edge x.
- obs_type_o  output  2  0 small cactus, 1 large cactus, 2 bird low, 3 bird high.

## Operation
- States: IDLE, GAP, ACTIVE. Internal 8-bit gap counter.
- Reset: state IDLE, gap 0, next_o 0, obs_valid_o 0, obs_x_o 0, obs_type_o 0.
- Any state with run_i low: go to IDLE next cycle.
  - Clears obs_valid_o, obs_x_o and obs_type_o.
  - No next_o pulse.
  - run_i low has priority over frame_i in the same cycle.
- IDLE with run_i high: load gap = MIN_GAP + rand_i[5:0] (8-bit add, no overflow by parameter rule), pulse next_o, and go to GAP. frame_i is not required.
- GAP, on frame_i:
  - If gap ≠ 0, decrement gap.
  - If gap == 0, spawn: obs_x_o = SCREEN_W-1, obs_type_o = rand_i[15:14], obs_valid_o = 1, pulse next_o, go to ACTIVE.
- ACTIVE, on frame_i:
  - If obs_x_o < speed_i, the obstacle has left. Set obs_valid_o = 0 and obs_x_o = 0, keep obs_type_o, reload gap = MIN_GAP + rand_i[5:0], pulse next_o, go to GAP.
  - Otherwise obs_x_o = obs_x_o - speed_i (10-bit, never underflows). obs_x_o = 0 is a valid on-screen position.
  - speed_i = 0 leaves the obstacle stationary; this is legal.
- No other state/frame combination changes state or outputs.
- Exactly one random word is consumed per next_o pulse. rand_i is never sampled in the cycle where next_o is high.

## Timing
- All outputs are registered. State, gap, obs_* and next_o all update on the same edge E at which the triggering inputs are sampled.
- next_o is high during the cycle after E only. The LFSR advances at E+1, so the next decision sees a fresh word.
- Latency:
  - run_i rising to GAP: 1 cycle.
  - Gap load G to spawn: the (G+1)th frame_i in GAP.
  - Exit to next spawn: MIN_GAP + rand_i[5:0] + 1 frames.
- The frame_i spacing rule guarantees no sample coincides with the pending LFSR advance.
- rst_i mid-operation: all registers return to reset values on the next edge, regardless of run_i or frame_i. A pending next_o is dropped.

## Test plan
- Reset, then run_i = 0 with 10 frame_i pulses → all outputs stay 0 and next_o never pulses.
- rand_i = 0x0005, run_i rises → next_o high exactly 1 cycle; obs_valid_o stays 0 through frames 1–25 and rises on frame 26 (gap 25).
- Spawn with rand_i = 0xC000, speed_i = 4 → obs_x_o = 639, obs_type_o = 3, next_o pulses once. After the next frame, obs_x_o = 635.
- Boundary with speed_i = 4:
  - obs_x_o = 4 → frame → 0 and still valid.
  - Next frame → obs_valid_o = 0, next_o pulses, gap reloaded.
  - Separately, obs_x_o = 3 → exits on the first frame.
  - speed_i = 0 → obs_x_o is unchanged over 5 frames.
- run_i falls in ACTIVE in the same cycle as frame_i → IDLE next cycle with obs_valid_o = 0, obs_x_o = 0 and no next_o. run_i rising again → new gap load with one next_o pulse.
- rst_i asserted in GAP and again in ACTIVE (with frame_i high) → every output is 0 the next cycle and state is IDLE.

Source files
------------

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: schedules one scrolling obstacle per random gap and requests LFSR advances.
// Ports: clk_i/rst_i clock and sync reset; run_i game level; frame_i frame tick; speed_i scroll px/frame;
// rand_i LFSR word; next_o LFSR advance pulse; obs_valid_o/obs_x_o/obs_type_o obstacle state.
module obstacle_spawner #(
  parameter int SCREEN_W = 640,
  parameter int MIN_GAP  = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       frame_i,
  input  logic [3:0] speed_i,
  input  logic [15:0] rand_i,
  output logic       next_o,
  output logic       obs_valid_o,
  output logic [9:0] obs_x_o,
  output logic [1:0] obs_type_o
);
  typedef enum logic [1:0] {IDLE, GAP, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic next_q, next_d, valid_q, valid_d;
  logic [9:0] x_q, x_d;
  logic [1:0] type_q, type_d;
  logic [7:0] gap_load;
  logic unused_rand;
  assign unused_rand = ^rand_i[13:6];
  assign gap_load = 8'(MIN_GAP) + {2'b00, rand_i[5:0]};
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    next_d = 1'b0;
    valid_d = valid_q;
    x_d = x_q;
    type_d = type_q;
    if (!run_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      x_d = '0;
      type_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          gap_d = gap_load;
          next_d = 1'b1;
          state_d = GAP;
        end
        GAP: if (frame_i) begin
          if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
          else begin
            x_d = 10'(SCREEN_W - 1);
            type_d = rand_i[15:14];
            valid_d = 1'b1;
            next_d = 1'b1;
            state_d = ACTIVE;
          end
        end
        ACTIVE: if (frame_i) begin
          if (x_q < {6'd0, speed_i}) begin
            valid_d = 1'b0;
            x_d = '0;
            gap_d = gap_load;
            next_d = 1'b1;
            state_d = GAP;
          end else x_d = x_q - {6'd0, speed_i};
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gap_q <= '0;
      next_q <= 1'b0;
      valid_q <= 1'b0;
      x_q <= '0;
      type_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      next_q <= next_d;
      valid_q <= valid_d;
      x_q <= x_d;
      type_q <= type_d;
    end
  end
  assign next_o = next_q;
  assign obs_valid_o = valid_q;
  assign obs_x_o = x_q;
  assign obs_type_o = type_q;
endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed self-checking bench for obstacle_spawner.
module tb_obstacle_spawner;
  logic clk_i = 0, rst_i = 0, run_i = 0, frame_i = 0;
  logic [3:0] speed_i = 0;
  logic [15:0] rand_i = 0;
  logic next_o, obs_valid_o;
  logic [9:0] obs_x_o;
  logic [1:0] obs_type_o;
  int errors = 0, checks = 0, next_cnt = 0, c0;
  obstacle_spawner #(.SCREEN_W(640), .MIN_GAP(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .frame_i(frame_i), .speed_i(speed_i),
    .rand_i(rand_i), .next_o(next_o), .obs_valid_o(obs_valid_o), .obs_x_o(obs_x_o),
    .obs_type_o(obs_type_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (next_o) next_cnt++;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_i = 1;
      step();
      frame_i = 0;
      step();
    end
  endtask
  task automatic check_outs(input string name, input logic v, input logic [9:0] x, input logic [1:0] t);
    checks++;
    if (obs_valid_o !== v || obs_x_o !== x || obs_type_o !== t) begin
      errors++;
      $display("FAIL %s: got v=%b x=%0d t=%0d, want v=%b x=%0d t=%0d", name, obs_valid_o, obs_x_o, obs_type_o, v, x, t);
    end
  endtask
  task automatic test_reset();
    rst_i = 1;
    step();
    rst_i = 0;
    checks++;
    if (next_o !== 0 || obs_valid_o !== 0 || obs_x_o !== 0 || obs_type_o !== 0) begin
      errors++;
      $display("FAIL reset: got n=%b v=%b x=%0d t=%0d, want all 0", next_o, obs_valid_o, obs_x_o, obs_type_o);
    end
    c0 = next_cnt;
    rand_i = 16'hFFFF;
    frames(10);
    check_outs("idle_frames", 0, 0, 0);
    checks++;
    if (next_cnt - c0 !== 0) begin
      errors++;
      $display("FAIL idle_next: got %0d pulses, want 0", next_cnt - c0);
    end
  endtask
  task automatic test_gap_and_spawn();
    logic bad = 0;
    rand_i = 16'h0005;
    speed_i = 4;
    c0 = next_cnt;
    run_i = 1;
    step();
    checks++;
    if (next_o !== 1) begin errors++; $display("FAIL run_next_hi: got %b want 1", next_o); end
    step();
    checks++;
    if (next_o !== 0) begin errors++; $display("FAIL run_next_lo: got %b want 0", next_o); end
    for (int i = 0; i < 25; i++) begin
      frames(1);
      if (obs_valid_o !== 0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL gap25: valid rose early, got 1 want 0"); end
    rand_i = 16'hC000;
    frames(1);
    check_outs("spawn", 1, 639, 3);
    checks++;
    if (next_cnt - c0 !== 2) begin errors++; $display("FAIL spawn_next: got %0d pulses want 2", next_cnt - c0); end
    frames(1);
    check_outs("scroll4", 1, 635, 3);
  endtask
  task automatic test_boundary();
    logic bad = 0;
    speed_i = 0;
    frames(5);
    check_outs("speed0", 1, 635, 3);
    speed_i = 15;
    frames(42);
    check_outs("scroll15", 1, 5, 3);
    speed_i = 1;
    frames(1);
    check_outs("x4", 1, 4, 3);
    speed_i = 4;
    frames(1);
    check_outs("x0_valid", 1, 0, 3);
    c0 = next_cnt;
    frames(1);
    check_outs("exit", 0, 0, 3);
    checks++;
    if (next_cnt - c0 !== 1) begin errors++; $display("FAIL exit_next: got %0d pulses want 1", next_cnt - c0); end
    for (int i = 0; i < 20; i++) begin
      frames(1);
      if (obs_valid_o !== 0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reload_gap20: valid rose early, got 1 want 0"); end
    frames(1);
    check_outs("respawn", 1, 639, 3);
    speed_i = 15;
    frames(42);
    speed_i = 6;
    frames(1);
    check_outs("x3", 1, 3, 3);
    speed_i = 4;
    frames(1);
    check_outs("x3_exit", 0, 0, 3);
  endtask
  task automatic test_run_drop();
    rand_i = 16'h4000;
    frames(21);
    check_outs("spawn_t1", 1, 639, 1);
    c0 = next_cnt;
    run_i = 0;
    frame_i = 1;
    step();
    frame_i = 0;
    check_outs("run_drop", 0, 0, 0);
    step();
    checks++;
    if (next_cnt - c0 !== 0) begin errors++; $display("FAIL drop_next: got %0d pulses want 0", next_cnt - c0); end
    run_i = 1;
    step();
    step();
    checks++;
    if (next_cnt - c0 !== 1) begin errors++; $display("FAIL rerun_next: got %0d pulses want 1", next_cnt - c0); end
  endtask
  task automatic test_reset_midop();
    frames(3);
    rst_i = 1;
    step();
    rst_i = 0;
    checks++;
    if (next_o !== 0 || obs_valid_o !== 0 || obs_x_o !== 0 || obs_type_o !== 0) begin
      errors++;
      $display("FAIL rst_gap: got n=%b v=%b x=%0d t=%0d, want all 0", next_o, obs_valid_o, obs_x_o, obs_type_o);
    end
    step();
    checks++;
    if (next_o !== 1) begin errors++; $display("FAIL rst_gap_idle: next got %b want 1", next_o); end
    step();
    frames(21);
    check_outs("spawn_again", 1, 639, 1);
    rst_i = 1;
    frame_i = 1;
    step();
    rst_i = 0;
    frame_i = 0;
    checks++;
    if (next_o !== 0 || obs_valid_o !== 0 || obs_x_o !== 0 || obs_type_o !== 0) begin
      errors++;
      $display("FAIL rst_active: got n=%b v=%b x=%0d t=%0d, want all 0", next_o, obs_valid_o, obs_x_o, obs_type_o);
    end
    step();
    checks++;
    if (next_o !== 1) begin errors++; $display("FAIL rst_active_idle: next got %b want 1", next_o); end
  endtask
  initial begin
    test_reset();
    test_gap_and_spawn();
    test_boundary();
    test_run_drop();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
